// File: rtl/leaf_out_arbiter_if.sv
// User-side stream bundle of the leaf output arbiter: per-port payload/valid/ack
// toward the users, registered BFT packet and ready toward the fabric.
interface leaf_out_arbiter_if #(
    parameter int NUM_OUT_PORTS = 5,
    parameter int PAYLOAD_BITS  = 32,
    parameter int PACKET_BITS   = 49
);
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
    logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
    logic                                  bft_ready;
    logic [PACKET_BITS-1:0]                dout_leaf_interface2bft;

    // Environment side: users and downstream fabric.
    modport master (
        output din_leaf_user2interface,
        output vld_user2interface,
        output bft_ready,
        input  ack_interface2user,
        input  dout_leaf_interface2bft
    );

    // Arbiter side.
    modport slave (
        input  din_leaf_user2interface,
        input  vld_user2interface,
        input  bft_ready,
        output ack_interface2user,
        output dout_leaf_interface2bft
    );
endinterface

// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter merging NUM_OUT_PORTS user streams into one registered BFT packet.
// Optional per-port credit gating is compiled in when LEAF_OUT_ARB_CREDIT_EN is defined.
module leaf_out_arbiter #(
    parameter int NUM_OUT_PORTS = 5,
    parameter int PAYLOAD_BITS  = 32,
    parameter int PACKET_BITS   = 49,
    parameter int NUM_LEAF_BITS = 5,
    parameter int NUM_PORT_BITS = 4,
    parameter int CREDIT_BITS   = 8,
    parameter int CREDIT_INIT   = 64
) (
    input  logic                             clk,
    input  logic                             reset_n,
    leaf_out_arbiter_if.slave                bus,
    input  logic                             cfg_we,
    input  logic [$clog2(NUM_OUT_PORTS)-1:0] cfg_port,
    input  logic [NUM_LEAF_BITS-1:0]         cfg_dst_leaf,
    input  logic [NUM_PORT_BITS-1:0]         cfg_dst_port,
    input  logic                             credit_upd_vld,
    input  logic [$clog2(NUM_OUT_PORTS)-1:0] credit_upd_port,
    input  logic [CREDIT_BITS-1:0]           credit_upd_amt,
    input  logic                             resend
);
    localparam int SEL_W     = $clog2(NUM_OUT_PORTS);
    localparam int BODY_BITS = PACKET_BITS - 1;
    localparam int PAD_BITS  = BODY_BITS - NUM_LEAF_BITS - NUM_PORT_BITS - PAYLOAD_BITS;

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

    out_state_t                 state_q, state_d;
    logic [BODY_BITS-1:0]       body_q;
    logic [SEL_W-1:0]           last_grant_q;
    logic [NUM_LEAF_BITS-1:0]   dst_leaf_q [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0]   dst_port_q [NUM_OUT_PORTS];
    logic [PAYLOAD_BITS-1:0]    payload [NUM_OUT_PORTS];
    logic [NUM_OUT_PORTS-1:0]   credit_ok;
    logic [NUM_OUT_PORTS-1:0]   eligible;
    logic                       can_load;
    logic                       grant_vld;
    logic [SEL_W-1:0]           grant_idx;
    int                         rr_idx;
    logic                       cfg_hit;

    assign cfg_hit = cfg_we && (int'(cfg_port) < NUM_OUT_PORTS);

    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            payload[i] = bus.din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
    end

    // A new packet may load only when the output slot is free or drains this cycle.
    assign can_load = reset_n && !resend && ((state_q == OUT_EMPTY) || bus.bft_ready);
    assign eligible = bus.vld_user2interface & credit_ok & {NUM_OUT_PORTS{can_load}};

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
            rr_idx = (int'(last_grant_q) + k) % NUM_OUT_PORTS;
            if (!grant_vld && eligible[SEL_W'(rr_idx)]) begin
                grant_vld = 1'b1;
                grant_idx = SEL_W'(rr_idx);
            end
        end
    end

    assign bus.ack_interface2user = grant_vld ? (NUM_OUT_PORTS'(1) << grant_idx) : '0;
    assign bus.dout_leaf_interface2bft = {state_q == OUT_FULL, body_q};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OUT_EMPTY: if (grant_vld) state_d = OUT_FULL;
            OUT_FULL: begin
                if (grant_vld)          state_d = OUT_FULL;
                else if (bus.bft_ready) state_d = OUT_EMPTY;
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= OUT_EMPTY;
            body_q       <= '0;
            last_grant_q <= SEL_W'(NUM_OUT_PORTS - 1);
        end else begin
            state_q <= state_d;
            if (grant_vld) begin
                body_q <= {dst_leaf_q[grant_idx], dst_port_q[grant_idx],
                           {PAD_BITS{1'b0}}, payload[grant_idx]};
                last_grant_q <= grant_idx;
            end
        end
    end

    // NOTE: the destination table is a handful of flops, so it is reset like any other state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                dst_leaf_q[i] <= '0;
                dst_port_q[i] <= '0;
            end
        end else if (cfg_hit) begin
            dst_leaf_q[cfg_port] <= cfg_dst_leaf;
            dst_port_q[cfg_port] <= cfg_dst_port;
        end
    end

`ifdef LEAF_OUT_ARB_CREDIT_EN
    logic [CREDIT_BITS-1:0] credit_q   [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0] credit_d   [NUM_OUT_PORTS];
    logic [CREDIT_BITS:0]   credit_sum [NUM_OUT_PORTS];
    logic                   upd_hit;

    assign upd_hit = credit_upd_vld && (int'(credit_upd_port) < NUM_OUT_PORTS);

    // One extra bit holds credit+amt-1 exactly; the grant only fires with credit>0,
    // so the subtraction never wraps.
    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_ok[i]  = (credit_q[i] != '0);
            credit_sum[i] = {1'b0, credit_q[i]};
            if (upd_hit && (credit_upd_port == SEL_W'(i)))
                credit_sum[i] = credit_sum[i] + {1'b0, credit_upd_amt};
            if (grant_vld && (grant_idx == SEL_W'(i)))
                credit_sum[i] = credit_sum[i] - (CREDIT_BITS+1)'(1);
            credit_d[i] = credit_sum[i][CREDIT_BITS] ? '1 : credit_sum[i][CREDIT_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (!reset_n) credit_q[i] <= CREDIT_BITS'(CREDIT_INIT);
            else          credit_q[i] <= credit_d[i];
        end
    end
`else
    logic unused_credit;

    assign credit_ok     = '1;
    assign unused_credit = ^{credit_upd_vld, credit_upd_port, credit_upd_amt,
                             CREDIT_BITS'(CREDIT_INIT)};
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Self-checking bench for leaf_out_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural reference model.
module tb_leaf_out_arbiter;
    localparam int N    = 5;
    localparam int PB   = 32;
    localparam int KB   = 49;
    localparam int CINIT = 64;
    localparam int CMAX  = 255;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cfg_we;
    logic [2:0] cfg_port;
    logic [4:0] cfg_dst_leaf;
    logic [3:0] cfg_dst_port;
    logic       credit_upd_vld;
    logic [2:0] credit_upd_port;
    logic [7:0] credit_upd_amt;
    logic       resend;

    leaf_out_arbiter_if #(.NUM_OUT_PORTS(N), .PAYLOAD_BITS(PB), .PACKET_BITS(KB)) bus ();

    leaf_out_arbiter #(
        .NUM_OUT_PORTS(N), .PAYLOAD_BITS(PB), .PACKET_BITS(KB),
        .NUM_LEAF_BITS(5), .NUM_PORT_BITS(4), .CREDIT_BITS(8), .CREDIT_INIT(CINIT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bus             (bus.slave),
        .cfg_we          (cfg_we),
        .cfg_port        (cfg_port),
        .cfg_dst_leaf    (cfg_dst_leaf),
        .cfg_dst_port    (cfg_dst_port),
        .credit_upd_vld  (credit_upd_vld),
        .credit_upd_port (credit_upd_port),
        .credit_upd_amt  (credit_upd_amt),
        .resend          (resend)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int          cred_m [N];
    logic [4:0]  leaf_m [N];
    logic [3:0]  port_m [N];
    int          last_m;
    logic [KB-1:0] dout_m;
    logic [N-1:0]  ack_seen;

    typedef struct {
        logic [N-1:0] vld;
        logic         rdy;
        logic         rs;
        logic [N-1:0] ack;
        logic         v;
    } vec_t;
    vec_t tbl [20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic credit_allows(input int p);
`ifdef LEAF_OUT_ARB_CREDIT_EN
        return cred_m[p] > 0;
`else
        return (p >= 0);
`endif
    endfunction

    // Winner is the first valid port with credit, searching from the port after the last winner.
    function automatic logic [N-1:0] model_ack();
        if (!reset_n || resend || (dout_m[KB-1] && !bus.bft_ready)) return '0;
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (last_m + k) % N;
            if (bus.vld_user2interface[p] && credit_allows(p)) return N'(1) << p;
        end
        return '0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            cred_m[i] = CINIT;
            leaf_m[i] = '0;
            port_m[i] = '0;
        end
        last_m = N - 1;
        dout_m = '0;
    endtask

    task automatic model_edge(input logic [N-1:0] ea);
        int p;
        p = -1;
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++) if (ea[i]) p = i;
        if (p >= 0) begin
            dout_m = {1'b1, leaf_m[p], port_m[p], 7'd0, bus.din_leaf_user2interface[p*PB +: PB]};
            last_m = p;
        end else if (bus.bft_ready) begin
            dout_m[KB-1] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            int c;
            c = cred_m[i];
            if (credit_upd_vld && int'(credit_upd_port) == i) c += int'(credit_upd_amt);
            if (p == i) c -= 1;
            cred_m[i] = (c > CMAX) ? CMAX : c;
        end
        if (cfg_we && int'(cfg_port) < N) begin
            leaf_m[cfg_port] = cfg_dst_leaf;
            port_m[cfg_port] = cfg_dst_port;
        end
    endtask

    // Called at posedge+1 with inputs already set; returns at the next posedge+1.
    task automatic step(input logic has_tbl, input logic [N-1:0] t_ack, input logic t_v);
        logic [N-1:0] ea;
        #3;
        ea = model_ack();
        ack_seen = bus.ack_interface2user;
        check("ack", 64'(bus.ack_interface2user), 64'(ea));
        if (has_tbl) check("tbl_ack", 64'(bus.ack_interface2user), 64'(t_ack));
        @(posedge clk);
        model_edge(ea);
        #1;
        check("dout", 64'(bus.dout_leaf_interface2bft), 64'(dout_m));
        if (has_tbl) check("tbl_vbit", 64'(bus.dout_leaf_interface2bft[KB-1]), 64'(t_v));
    endtask

    task automatic drive(input logic [N-1:0] vld, input logic rdy, input logic rs);
        bus.vld_user2interface = vld;
        bus.bft_ready          = rdy;
        resend                 = rs;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [KB-1:0] e34;
        int guard;

        tbl[0]  = '{5'b11111, 1'b1, 1'b0, 5'b00001, 1'b1};
        tbl[1]  = '{5'b11111, 1'b1, 1'b0, 5'b00010, 1'b1};
        tbl[2]  = '{5'b11111, 1'b1, 1'b0, 5'b00100, 1'b1};
        tbl[3]  = '{5'b11111, 1'b1, 1'b0, 5'b01000, 1'b1};
        tbl[4]  = '{5'b11111, 1'b1, 1'b0, 5'b10000, 1'b1};
        tbl[5]  = '{5'b11111, 1'b1, 1'b1, 5'b00000, 1'b0};
        tbl[6]  = '{5'b11111, 1'b1, 1'b1, 5'b00000, 1'b0};
        tbl[7]  = '{5'b11111, 1'b1, 1'b1, 5'b00000, 1'b0};
        tbl[8]  = '{5'b11111, 1'b1, 1'b1, 5'b00000, 1'b0};
        tbl[9]  = '{5'b11111, 1'b1, 1'b0, 5'b00001, 1'b1};
        tbl[10] = '{5'b00000, 1'b0, 1'b0, 5'b00000, 1'b1};
        tbl[11] = '{5'b00001, 1'b0, 1'b0, 5'b00000, 1'b1};
        tbl[12] = '{5'b00001, 1'b1, 1'b0, 5'b00001, 1'b1};
        tbl[13] = '{5'b00100, 1'b1, 1'b0, 5'b00100, 1'b1};
        tbl[14] = '{5'b01001, 1'b1, 1'b0, 5'b01000, 1'b1};
        tbl[15] = '{5'b01001, 1'b1, 1'b0, 5'b00001, 1'b1};
        tbl[16] = '{5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0};
        tbl[17] = '{5'b00010, 1'b0, 1'b0, 5'b00010, 1'b1};
        tbl[18] = '{5'b00000, 1'b0, 1'b0, 5'b00000, 1'b1};
        tbl[19] = '{5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0};

        model_reset();
        reset_n = 1'b0;
        cfg_we = 1'b0; cfg_port = '0; cfg_dst_leaf = '0; cfg_dst_port = '0;
        credit_upd_vld = 1'b0; credit_upd_port = '0; credit_upd_amt = '0;
        drive('0, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) bus.din_leaf_user2interface[i*PB +: PB] = 32'hA000_0000 + i;
        @(posedge clk);
        #1;
        drive(5'b11111, 1'b1, 1'b0);
        step(1'b1, 5'b00000, 1'b0);
        step(1'b1, 5'b00000, 1'b0);
        reset_n = 1'b1;

        // Directed vectors: round-robin order, resend freeze, backpressure.
        for (int t = 0; t < 20; t++) begin
            drive(tbl[t].vld, tbl[t].rdy, tbl[t].rs);
            step(1'b1, tbl[t].ack, tbl[t].v);
        end

        // Table write, then same-cycle rewrite during a transfer keeps the old entry.
        e34 = {1'b1, 5'd9, 4'd3, 7'd0, 32'hDEADBEEF};
        bus.din_leaf_user2interface[2*PB +: PB] = 32'hDEADBEEF;
        cfg_we = 1'b1; cfg_port = 3'd2; cfg_dst_leaf = 5'd9; cfg_dst_port = 4'd3;
        drive(5'b00000, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0);
        cfg_dst_leaf = 5'd17; cfg_dst_port = 4'd1;
        drive(5'b00100, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0);
        check("dst_table", 64'(bus.dout_leaf_interface2bft), 64'(e34));
        cfg_we = 1'b0;
        step(1'b0, '0, 1'b0);
        check("dst_rewrite", 64'(bus.dout_leaf_interface2bft),
              64'({1'b1, 5'd17, 4'd1, 7'd0, 32'hDEADBEEF}));

        // Out-of-range table write is dropped.
        cfg_we = 1'b1; cfg_port = 3'd6; cfg_dst_leaf = 5'd31; cfg_dst_port = 4'd15;
        drive(5'b00000, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0);
        cfg_we = 1'b0;

        // Reset while the output register holds a packet.
        drive(5'b00001, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0);
        reset_n = 1'b0;
        drive(5'b11111, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0);
        check("reset_ack", 64'(ack_seen), 64'd0);
        check("reset_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        reset_n = 1'b1;
        drive(5'b00000, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0);

`ifdef LEAF_OUT_ARB_CREDIT_EN
        // Exhaust port 1, confirm it stalls, then return one credit.
        drive(5'b00010, 1'b1, 1'b0);
        guard = 0;
        while (cred_m[1] > 0 && guard < 300) begin
            step(1'b0, '0, 1'b0);
            guard++;
        end
        check("credit_drained", 64'(cred_m[1]), 64'd0);
        step(1'b0, '0, 1'b0);
        check("credit_block", 64'(ack_seen), 64'd0);
        credit_upd_vld = 1'b1; credit_upd_port = 3'd1; credit_upd_amt = 8'd1;
        step(1'b0, '0, 1'b0);
        credit_upd_vld = 1'b0;
        step(1'b0, '0, 1'b0);
        check("credit_resume", 64'(ack_seen), 64'(5'b00010));
`else
        guard = 0;
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) bus.din_leaf_user2interface[i*PB +: PB] = $urandom;
            drive(N'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
            cfg_we          = $urandom_range(0, 7) == 0;
            cfg_port        = 3'($urandom_range(0, 7));
            cfg_dst_leaf    = 5'($urandom);
            cfg_dst_port    = 4'($urandom);
            credit_upd_vld  = $urandom_range(0, 3) == 0;
            credit_upd_port = 3'($urandom_range(0, 7));
            credit_upd_amt  = ($urandom_range(0, 19) == 0) ? 8'd255 : 8'($urandom_range(0, 2));
            reset_n         = $urandom_range(0, 99) != 0;
            step(1'b0, '0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
